line_centroid_tracker: RTL and testbench
========================================

# line_centroid_tracker

Consumes the thresholded 1-bit pixel stream produced by the camera capture/threshold stage, in the camera pixel-clock domain alongside the frame buffer write port. It splits each frame into horizontal bands, computes the horizontal centroid of line pixels per band, and emits one band result per band plus a per-frame summary. The MCU steering loop uses these results without reading the full frame.

## Interface
Parameters:
- IMG_W, 320: pixels per row.
- IMG_H, 240: rows per frame.
- N_BANDS, 8: bands per frame. IMG_H must be a multiple of N_BANDS, giving 30 rows per band.
- MIN_PIX, 16: minimum line-pixel count for a band to count as found.

Ports:
- cam_pclk  in  1  sole clock.
- nreset  in  1  asynchronous, active-low reset.
- px_valid  in  1  pixel strobe, from the capture stage wr_en.
- px_addr  in  17  linear pixel address, from the capture stage wr_addr.
- px_bit  in  1  thresholded pixel; 1 means line pixel.
- frame_done  in  1  one-cycle end-of-frame pulse.
- band_valid  out  1  one-cycle result strobe.
- band_idx  out  3  band number, 0 is the top band.
- band_found  out  1  band count ≥ MIN_PIX.
- band_centroid  out  9  floor(sum_x / count), in the range 0..IMG_W-1.
- band_count  out  14  line pixels in the band (max 9600).
- frame_valid  out  1  one-cycle pulse, the cycle after band N_BANDS-1 is reported.
- frame_err  out  10  signed steering error.
- frame_short  out  1  one-cycle pulse: frame aborted before the last band closed.

## Operation
Reset:
- Every output resets to 0.
- x, y, band, sum and count reset to 0; the divider resets to idle.

Pixel handling:
- A pixel is accepted on any cycle with px_valid=1.
- px_valid=1 with px_addr=0 resynchronises x=y=band=0 and clears the accumulators before that pixel is accumulated.
- For an accepted pixel with px_bit=1: sum += x (22-bit, no overflow possible) and count += 1.
- After each accepted pixel, x increments and wraps at IMG_W, incrementing y.
- When y crosses a band boundary (every IMG_H/N_BANDS rows), the band closes:
  - sum, count and band index are latched into the divider;
  - the accumulators clear;
  - band increments.

Division:
- Sub-module restoring divider, 9-bit quotient, truncating.
- count=0 bypasses the division: centroid = IMG_W/2 and found=0. Latency is identical to the normal path.
- A band closing while the divider is busy cannot occur at legal parameters. If it does, the new band result is dropped; no other effect.

frame_done behaviour:
- After the last band closes: x, y and band reset; no frame_short.
- Mid-frame: the partial band is discarded, with no band_valid. Counters reset and frame_short pulses the next cycle. An in-flight division still completes and reports.
- frame_done coincident with the last pixel: the pixel is accepted, the band closes normally, then the counters reset.

## Timing
Band result:
- Edge E accepts the closing pixel.
- E+1: divider loads.
- E+2..E+10: nine iteration cycles.
- band_valid and all band_* outputs update at edge E+11 (11-cycle latency).
- band_* outputs hold until the next band_valid.

Frame result:
- frame_valid and frame_err update one edge after band N_BANDS-1's band_valid.
- frame_err holds until the next frame_valid.

Input cadence:
- px_valid may be high every cycle or sparse.
- Minimum band length (IMG_W×rows ≫ 11 cycles) guarantees the divider is free at each band close.

## Configuration
LINE_TRACK_ERR_EN:
- Defined: frame_err = band_centroid(band N_BANDS-1) − IMG_W/2, signed 10-bit. If that band is not found, frame_err holds its previous value.
- Undefined: frame_err is tied to 0 and no subtractor is built. frame_valid still pulses.

## Structure
- Shared package line_track_pkg holds:
  - the IMG_W, IMG_H and N_BANDS defaults;
  - the derived ROWS_PER_BAND;
  - SUM_W=22, CNT_W=14, CENT_W=9;
  - a band_result_t struct (idx, found, centroid, count).
- One sub-module: centroid_divider, a sequential 22/14 → 9-bit restoring divider with start/busy/done and the zero-count bypass.

## Test plan
- Full 320×240 frame, line pixels at columns 100..109 in every row → 8 band_valid pulses, band_idx 0..7, centroid 104, count 300, found=1. frame_valid follows, frame_err=−56 with LINE_TRACK_ERR_EN defined.
- All-zero frame → every band: count 0, centroid 160, found=0. frame_err stays at the prior value.
- Band 3 contains only 15 line pixels at x=200 → count 15, centroid 200, found=0.
- frame_done injected mid-band 5 → no band 5 result, frame_short pulse, no frame_valid. The next frame reports normally from band 0.
- nreset asserted during a division → all outputs 0 immediately, no stale band_valid after release.
- px_valid at 50% duty with a gap placed at band close → band_valid exactly 11 edges after the accepting edge.

Source files
------------

// File: rtl/line_track_pkg.sv
// Shared types and constants for the line centroid tracker.
// Holds the default frame geometry, the datapath widths, the band result
// record and the steering-error helper.
package line_track_pkg;

    localparam int IMG_W_DEF     = 320;
    localparam int IMG_H_DEF     = 240;
    localparam int N_BANDS_DEF   = 8;
    localparam int MIN_PIX_DEF   = 16;
    localparam int ROWS_PER_BAND = IMG_H_DEF / N_BANDS_DEF;

    localparam int SUM_W  = 22;
    localparam int CNT_W  = 14;
    localparam int CENT_W = 9;
    localparam int IDX_W  = 3;
    localparam int ERR_W  = 10;
    localparam int ADDR_W = 17;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              found;
        logic [CENT_W-1:0] centroid;
        logic [CNT_W-1:0]  count;
    } band_result_t;

    // Signed distance of a centroid from the image centre, 10-bit two's complement.
    function automatic logic [ERR_W-1:0] steer_err(input logic [CENT_W-1:0] cent,
                                                   input logic [CENT_W-1:0] ctr);
        steer_err = {1'b0, cent} - {1'b0, ctr};
    endfunction

endpackage

// File: rtl/centroid_divider.sv
// Sequential restoring divider: sum / count -> 9-bit truncated quotient.
// One load cycle, then CENT_W iteration cycles; o_done pulses with the
// finished band result. A zero count takes the same number of cycles and
// reports the image centre with found cleared. A start while busy is ignored.
module centroid_divider
    import line_track_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [SUM_W-1:0]   i_sum,
    input  logic [CNT_W-1:0]   i_cnt,
    input  logic [IDX_W-1:0]   i_idx,
    output logic               o_busy,
    output logic               o_done,
    output band_result_t       o_result
);

    localparam logic [CENT_W-1:0] C_CENTER    = CENT_W'(IMG_W / 2);
    localparam logic [CNT_W-1:0]  C_MIN       = CNT_W'(MIN_PIX);
    localparam logic [3:0]        C_LAST_ITER = 4'(CENT_W - 1);

    logic              r_busy;
    logic              r_done;
    logic [SUM_W-1:0]  r_rem;
    logic [SUM_W-1:0]  r_dvs;
    logic [CENT_W-2:0] r_q;
    logic [3:0]        r_iter;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_zero;
    band_result_t      r_result;

    logic              w_ge;
    logic [SUM_W-1:0]  w_rem_sub;
    logic [CENT_W-1:0] w_q_next;

    // One restoring step: compare the remainder against the shifted divisor.
    always_comb begin
        w_ge      = (r_rem >= r_dvs);
        w_rem_sub = r_rem - r_dvs;
        w_q_next  = {r_q, w_ge};
    end

    // Load on start, iterate while busy, publish the result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rem    <= {SUM_W{1'b0}};
            r_dvs    <= {SUM_W{1'b0}};
            r_q      <= {(CENT_W-1){1'b0}};
            r_iter   <= 4'd0;
            r_cnt    <= {CNT_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
            r_zero   <= 1'b0;
            r_result <= '{idx: {IDX_W{1'b0}}, found: 1'b0,
                          centroid: {CENT_W{1'b0}}, count: {CNT_W{1'b0}}};
        end else begin
            r_done <= 1'b0;
            if (r_busy) begin
                if (w_ge) begin
                    r_rem <= w_rem_sub;
                end
                r_dvs  <= r_dvs >> 1;
                r_q    <= w_q_next[CENT_W-2:0];
                r_iter <= r_iter + 4'd1;
                if (r_iter == C_LAST_ITER) begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= '{idx: r_idx,
                                  found: (!r_zero) && (r_cnt >= C_MIN),
                                  centroid: r_zero ? C_CENTER : w_q_next,
                                  count: r_cnt};
                end
            end else if (i_start) begin
                r_busy <= 1'b1;
                r_rem  <= i_sum;
                r_dvs  <= SUM_W'(i_cnt) << (CENT_W - 1);
                r_q    <= {(CENT_W-1){1'b0}};
                r_iter <= 4'd0;
                r_cnt  <= i_cnt;
                r_idx  <= i_idx;
                r_zero <= (i_cnt == {CNT_W{1'b0}});
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: rtl/line_centroid_tracker.sv
// Per-band horizontal centroid of line pixels in a thresholded pixel stream.
// Tracks x / row-in-band / band from the pixel strobe, accumulates sum of x and
// pixel count per band, hands each closed band to centroid_divider and emits a
// band result plus a per-frame summary.
// Optional feature macro: LINE_TRACK_ERR_EN (frame steering error subtractor).
module line_centroid_tracker
    import line_track_pkg::*;
#(
    parameter int IMG_W   = IMG_W_DEF,
    parameter int IMG_H   = IMG_H_DEF,
    parameter int N_BANDS = N_BANDS_DEF,
    parameter int MIN_PIX = MIN_PIX_DEF
) (
    input  logic              cam_pclk,
    input  logic              nreset,
    input  logic              px_valid,
    input  logic [ADDR_W-1:0] px_addr,
    input  logic              px_bit,
    input  logic              frame_done,
    output logic              band_valid,
    output logic [IDX_W-1:0]  band_idx,
    output logic              band_found,
    output logic [CENT_W-1:0] band_centroid,
    output logic [CNT_W-1:0]  band_count,
    output logic              frame_valid,
    output logic [ERR_W-1:0]  frame_err,
    output logic              frame_short
);

    localparam int ROWS  = IMG_H / N_BANDS;
    localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [X_W-1:0]    C_X_LAST    = X_W'(IMG_W - 1);
    localparam logic [X_W-1:0]    C_X_ONE     = X_W'(1);
    localparam logic [ROW_W-1:0]  C_ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  C_ROW_ONE   = ROW_W'(1);
    localparam logic [IDX_W-1:0]  C_BAND_LAST = IDX_W'(N_BANDS - 1);
    localparam logic [IDX_W-1:0]  C_BAND_ONE  = IDX_W'(1);

    // position and accumulators
    logic [X_W-1:0]    r_x;
    logic [ROW_W-1:0]  r_row;
    logic [IDX_W-1:0]  r_band;
    logic [SUM_W-1:0]  r_sum;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_active;
    // divider hand-off
    logic              r_start;
    logic [SUM_W-1:0]  r_ld_sum;
    logic [CNT_W-1:0]  r_ld_cnt;
    logic [IDX_W-1:0]  r_ld_idx;
    // registered outputs
    logic              r_band_valid;
    band_result_t      r_band_res;
    logic              r_frame_valid;
    logic              r_frame_short;

    logic              w_resync;
    logic [X_W-1:0]    w_base_x;
    logic [ROW_W-1:0]  w_base_row;
    logic [IDX_W-1:0]  w_base_band;
    logic [SUM_W-1:0]  w_base_sum;
    logic [CNT_W-1:0]  w_base_cnt;
    logic [SUM_W-1:0]  w_acc_sum;
    logic [CNT_W-1:0]  w_acc_cnt;
    logic              w_wrap;
    logic              w_close;
    logic              w_last_close;
    logic              w_load;
    logic [X_W-1:0]    w_x_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [IDX_W-1:0]  w_band_nxt;
    logic [SUM_W-1:0]  w_sum_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_active_nxt;
    logic              w_short;
    logic              w_div_busy;
    logic              w_div_done;
    band_result_t      w_div_res;

    // Resync on address 0, then accumulate the current pixel onto the base state.
    always_comb begin
        w_resync     = px_valid && (px_addr == {ADDR_W{1'b0}});
        w_base_x     = w_resync ? {X_W{1'b0}}   : r_x;
        w_base_row   = w_resync ? {ROW_W{1'b0}} : r_row;
        w_base_band  = w_resync ? {IDX_W{1'b0}} : r_band;
        w_base_sum   = w_resync ? {SUM_W{1'b0}} : r_sum;
        w_base_cnt   = w_resync ? {CNT_W{1'b0}} : r_cnt;
        w_acc_sum    = w_base_sum + ((px_valid && px_bit) ? SUM_W'(w_base_x) : {SUM_W{1'b0}});
        w_acc_cnt    = w_base_cnt + CNT_W'(px_valid && px_bit);
        w_wrap       = px_valid && (w_base_x == C_X_LAST);
        w_close      = w_wrap && (w_base_row == C_ROW_LAST);
        w_last_close = w_close && (w_base_band == C_BAND_LAST);
        w_load       = w_close && !w_div_busy && !r_start;
    end

    // Next position/accumulator state; frame_done overrides after the pixel is applied.
    always_comb begin
        w_x_nxt      = r_x;
        w_row_nxt    = r_row;
        w_band_nxt   = r_band;
        w_sum_nxt    = r_sum;
        w_cnt_nxt    = r_cnt;
        w_active_nxt = r_active;
        w_short      = 1'b0;
        if (px_valid) begin
            w_active_nxt = !w_last_close;
            if (w_close) begin
                w_x_nxt   = {X_W{1'b0}};
                w_row_nxt = {ROW_W{1'b0}};
                w_sum_nxt = {SUM_W{1'b0}};
                w_cnt_nxt = {CNT_W{1'b0}};
                if (w_last_close) begin
                    w_band_nxt = {IDX_W{1'b0}};
                end else begin
                    w_band_nxt = w_base_band + C_BAND_ONE;
                end
            end else if (w_wrap) begin
                w_x_nxt    = {X_W{1'b0}};
                w_row_nxt  = w_base_row + C_ROW_ONE;
                w_band_nxt = w_base_band;
                w_sum_nxt  = w_acc_sum;
                w_cnt_nxt  = w_acc_cnt;
            end else begin
                w_x_nxt    = w_base_x + C_X_ONE;
                w_row_nxt  = w_base_row;
                w_band_nxt = w_base_band;
                w_sum_nxt  = w_acc_sum;
                w_cnt_nxt  = w_acc_cnt;
            end
        end else begin
            w_active_nxt = r_active;
        end
        if (frame_done) begin
            w_short      = w_active_nxt;
            w_x_nxt      = {X_W{1'b0}};
            w_row_nxt    = {ROW_W{1'b0}};
            w_band_nxt   = {IDX_W{1'b0}};
            w_sum_nxt    = {SUM_W{1'b0}};
            w_cnt_nxt    = {CNT_W{1'b0}};
            w_active_nxt = 1'b0;
        end else begin
            w_short = 1'b0;
        end
    end

    // Position, accumulator and in-frame state registers.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            r_x      <= {X_W{1'b0}};
            r_row    <= {ROW_W{1'b0}};
            r_band   <= {IDX_W{1'b0}};
            r_sum    <= {SUM_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
            r_active <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_row    <= w_row_nxt;
            r_band   <= w_band_nxt;
            r_sum    <= w_sum_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
        end
    end

    // Latch a closed band for the divider; it picks it up on the next edge.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            r_start  <= 1'b0;
            r_ld_sum <= {SUM_W{1'b0}};
            r_ld_cnt <= {CNT_W{1'b0}};
            r_ld_idx <= {IDX_W{1'b0}};
        end else begin
            r_start <= w_load;
            if (w_load) begin
                r_ld_sum <= w_acc_sum;
                r_ld_cnt <= w_acc_cnt;
                r_ld_idx <= w_base_band;
            end
        end
    end

    centroid_divider #(
        .IMG_W   (IMG_W),
        .MIN_PIX (MIN_PIX)
    ) u_div (
        .clk      (cam_pclk),
        .rst_n    (nreset),
        .i_start  (r_start),
        .i_sum    (r_ld_sum),
        .i_cnt    (r_ld_cnt),
        .i_idx    (r_ld_idx),
        .o_busy   (w_div_busy),
        .o_done   (w_div_done),
        .o_result (w_div_res)
    );

    // Band and frame strobes; band fields hold until the next result.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            r_band_valid  <= 1'b0;
            r_band_res    <= '{idx: {IDX_W{1'b0}}, found: 1'b0,
                               centroid: {CENT_W{1'b0}}, count: {CNT_W{1'b0}}};
            r_frame_valid <= 1'b0;
            r_frame_short <= 1'b0;
        end else begin
            r_band_valid  <= w_div_done;
            if (w_div_done) begin
                r_band_res <= w_div_res;
            end
            r_frame_valid <= r_band_valid && (r_band_res.idx == C_BAND_LAST);
            r_frame_short <= w_short;
        end
    end

`ifdef LINE_TRACK_ERR_EN
    logic [ERR_W-1:0] r_frame_err;

    // Steering error from the bottom band, held when that band is not found.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            r_frame_err <= {ERR_W{1'b0}};
        end else if (r_band_valid && (r_band_res.idx == C_BAND_LAST) && r_band_res.found) begin
            r_frame_err <= steer_err(r_band_res.centroid, CENT_W'(IMG_W / 2));
        end
    end

    assign frame_err = r_frame_err;
`else
    assign frame_err = {ERR_W{1'b0}};
`endif

    assign band_valid    = r_band_valid;
    assign band_idx      = r_band_res.idx;
    assign band_found    = r_band_res.found;
    assign band_centroid = r_band_res.centroid;
    assign band_count    = r_band_res.count;
    assign frame_valid   = r_frame_valid;
    assign frame_short   = r_frame_short;

endmodule

// File: tb/tb_line_centroid_tracker.sv
// Self-checking bench for line_centroid_tracker on a reduced 32x128 frame
// (8 bands of 16 rows). A pixel-index model predicts every band result and
// its due cycle; a compare process checks all outputs each cycle.
module tb_line_centroid_tracker;

    localparam int W         = 32;
    localparam int H         = 128;
    localparam int NB        = 8;
    localparam int MINP      = 16;
    localparam int ROWS      = H / NB;
    localparam int BAND_PIX  = W * ROWS;
    localparam int FRAME_PIX = W * H;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        px_valid = 1'b0;
    logic [16:0] px_addr = 17'd0;
    logic        px_bit = 1'b0;
    logic        frame_done = 1'b0;
    logic        band_valid;
    logic [2:0]  band_idx;
    logic        band_found;
    logic [8:0]  band_centroid;
    logic [13:0] band_count;
    logic        frame_valid;
    logic [9:0]  frame_err;
    logic        frame_short;

    line_centroid_tracker #(.IMG_W(W), .IMG_H(H), .N_BANDS(NB), .MIN_PIX(MINP)) dut (
        .cam_pclk(clk), .nreset(nreset), .px_valid(px_valid), .px_addr(px_addr),
        .px_bit(px_bit), .frame_done(frame_done), .band_valid(band_valid),
        .band_idx(band_idx), .band_found(band_found), .band_centroid(band_centroid),
        .band_count(band_count), .frame_valid(frame_valid), .frame_err(frame_err),
        .frame_short(frame_short)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int idx; int found; int cent; int cnt; } exp_t;
    exp_t   q[$];
    int     pos = 0;
    longint bsum = 0;
    int     bcnt = 0;
    bit     active = 1'b0;
    int     fs_at = -1, fv_at = -1;
    int     e_idx = 0, e_found = 0, e_cent = 0, e_cnt = 0, e_err = 0;
    int     pend_found = 0, pend_err = 0;
    int     n_bv = 0, n_fv = 0, n_fs = 0;
    int     cap3_cent = -1, cap3_cnt = -1, cap3_found = -1;

    initial begin : model
        forever begin
            @(posedge clk or negedge nreset);
            if (!nreset) begin
                q.delete();
                pos = 0; bsum = 0; bcnt = 0; active = 1'b0;
                fs_at = -1; fv_at = -1;
                e_idx = 0; e_found = 0; e_cent = 0; e_cnt = 0; e_err = 0;
                pend_found = 0; pend_err = 0;
            end else begin
                cyc++;
                if (px_valid) begin
                    if (px_addr == 17'd0) begin pos = 0; bsum = 0; bcnt = 0; end
                    if (px_bit) begin bsum += pos % W; bcnt++; end
                    pos++;
                    active = 1'b1;
                    if (pos % BAND_PIX == 0) begin
                        q.push_back('{cyc + 11, pos / BAND_PIX - 1, (bcnt >= MINP) ? 1 : 0,
                                      (bcnt == 0) ? W / 2 : int'(bsum / bcnt), bcnt});
                        bsum = 0; bcnt = 0;
                        if (pos == FRAME_PIX) begin pos = 0; active = 1'b0; end
                    end
                end
                if (frame_done) begin
                    if (active) fs_at = cyc;
                    pos = 0; bsum = 0; bcnt = 0; active = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int ebv;
    initial begin : compare
        forever begin
            @(posedge clk); #2;
            if (nreset) begin
                while (q.size() > 0 && q[0].due < cyc) q.delete(0);
                ebv = (q.size() > 0 && q[0].due == cyc) ? 1 : 0;
                chk("band_valid", int'(band_valid), ebv);
                if (ebv == 1) begin
                    e_idx = q[0].idx; e_found = q[0].found; e_cent = q[0].cent; e_cnt = q[0].cnt;
                    q.delete(0);
                    if (e_idx == NB - 1) begin
                        fv_at = cyc + 1; pend_found = e_found; pend_err = e_cent - W / 2;
                    end
                end
                if (band_valid) begin
                    n_bv++;
                    if (band_idx == 3'd3) begin
                        cap3_cent = band_centroid; cap3_cnt = band_count; cap3_found = band_found;
                    end
                end
                chk("frame_valid", int'(frame_valid), (fv_at == cyc) ? 1 : 0);
`ifdef LINE_TRACK_ERR_EN
                if (fv_at == cyc && pend_found == 1) e_err = pend_err;
`endif
                if (frame_valid) n_fv++;
                if (frame_short) n_fs++;
                chk("band_idx", int'(band_idx), e_idx);
                chk("band_found", int'(band_found), e_found);
                chk("band_centroid", int'(band_centroid), e_cent);
                chk("band_count", int'(band_count), e_cnt);
                chk("frame_err", $signed(frame_err), e_err);
                chk("frame_short", int'(frame_short), (fs_at == cyc) ? 1 : 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic bit pix(input int kind, input int x, input int row, input int bth);
        case (kind)
            0: return (x >= 10 && x <= 19);
            1: return 1'b0;
            2: if (row / ROWS == 3) return (x == 20 && (row % ROWS) < 15);
               else return (x >= 10 && x <= 19);
            default: return ($urandom_range(0, BAND_PIX - 1) < bth);
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            px_valid = 1'b0; px_bit = 1'b0; frame_done = 1'b0;
        end
    endtask

    task automatic send_px(input int p, input bit b, input bit fd);
        @(negedge clk);
        px_valid = 1'b1; px_addr = 17'(p); px_bit = b; frame_done = fd;
    endtask

    task automatic send_frame(input int kind, input int abort_at, input bit sparse, input bit fd_last);
        int bth;
        bth = 0;
        for (int p = 0; p < FRAME_PIX; p++) begin
            if (p == abort_at) break;
            if (p % BAND_PIX == 0) bth = $urandom_range(0, 60);
            if (sparse) begin
                while ($urandom_range(0, 1) == 1) idle(1);
                if ((p + 1) % BAND_PIX == 0) idle(3);
            end
            send_px(p, pix(kind, p % W, p / W, bth), fd_last && (p == FRAME_PIX - 1));
            if (sparse && ((p + 1) % BAND_PIX == 0)) idle(2);
        end
        idle(1);
        if (abort_at >= 0 && abort_at < FRAME_PIX) begin
            @(negedge clk);
            px_valid = 1'b0; frame_done = 1'b1;
            idle(1);
        end
        idle(20);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " band_valid"}, int'(band_valid), 0);
        chk({tag, " band_idx"}, int'(band_idx), 0);
        chk({tag, " band_found"}, int'(band_found), 0);
        chk({tag, " band_centroid"}, int'(band_centroid), 0);
        chk({tag, " band_count"}, int'(band_count), 0);
        chk({tag, " frame_valid"}, int'(frame_valid), 0);
        chk({tag, " frame_err"}, int'(frame_err), 0);
        chk({tag, " frame_short"}, int'(frame_short), 0);
    endtask

    int bv0, fv0, fs0, exp_err;

    initial begin : driver
`ifdef LINE_TRACK_ERR_EN
        exp_err = -2;
`else
        exp_err = 0;
`endif
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        idle(2);

        // columns 10..19 every row: centroid floor(14.5)=14, count 160
        bv0 = n_bv; fv0 = n_fv;
        send_frame(0, -1, 1'b0, 1'b0);
        chk("A band pulses", n_bv - bv0, 8);
        chk("A frame pulses", n_fv - fv0, 1);
        chk("A last idx", int'(band_idx), 7);
        chk("A centroid", int'(band_centroid), 14);
        chk("A count", int'(band_count), 160);
        chk("A found", int'(band_found), 1);
        chk("A frame_err", $signed(frame_err), exp_err);

        // empty frame, frame_done on the last pixel
        bv0 = n_bv; fv0 = n_fv; fs0 = n_fs;
        send_frame(1, -1, 1'b0, 1'b1);
        chk("Z band pulses", n_bv - bv0, 8);
        chk("Z centroid", int'(band_centroid), 16);
        chk("Z count", int'(band_count), 0);
        chk("Z found", int'(band_found), 0);
        chk("Z frame_err held", $signed(frame_err), exp_err);
        chk("Z frame pulses", n_fv - fv0, 1);
        chk("Z short pulses", n_fs - fs0, 0);

        // band 3 holds 15 pixels at x=20
        cap3_cent = -1; cap3_cnt = -1; cap3_found = -1;
        send_frame(2, -1, 1'b0, 1'b0);
        chk("B3 centroid", cap3_cent, 20);
        chk("B3 count", cap3_cnt, 15);
        chk("B3 found", cap3_found, 0);

        // abort mid band 5
        bv0 = n_bv; fv0 = n_fv; fs0 = n_fs;
        send_frame(0, 5 * BAND_PIX + 100, 1'b0, 1'b0);
        chk("abort band pulses", n_bv - bv0, 5);
        chk("abort frame pulses", n_fv - fv0, 0);
        chk("abort short pulses", n_fs - fs0, 1);

        bv0 = n_bv; fv0 = n_fv;
        send_frame(0, -1, 1'b0, 1'b0);
        chk("next band pulses", n_bv - bv0, 8);
        chk("next frame pulses", n_fv - fv0, 1);
        chk("next centroid", int'(band_centroid), 14);

        // random content, sparse strobe with gaps around band close
        repeat (2) send_frame(3, -1, 1'b1, 1'b0);

        // reset while band 0 is being divided
        for (int p = 0; p < BAND_PIX + 4; p++) send_px(p, pix(0, p % W, p / W, 0), 1'b0);
        @(negedge clk);
        px_valid = 1'b0; px_bit = 1'b0;
        nreset = 1'b0;
        #1;
        check_zero("mid-div reset");
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        bv0 = n_bv;
        idle(20);
        chk("no stale band_valid", n_bv - bv0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
